// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_WAIT,
        ST_HOLD
    } fetch_state_e;

    localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;
    localparam logic [1:0] PCSRC_RSVD   = 2'b11;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory request/response bus; ready and rdata are valid in the same cycle.
interface fetch_stage_if;

    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);

endinterface

// File: rtl/fetch_stage_pc_next_mux.sv
// Combinational next-PC selection: sequential PC+4 or a redirect target.
module pc_next_mux
    import fetch_pkg::*;
(
    input  logic [31:0] pcf_i,
    input  logic [1:0]  pcsrc_i,
    input  logic [31:0] pc_target_i,
    input  logic [31:0] alu_result_i,
    output logic [31:0] pc_plus4_o,
    output logic        redirect_o,
    output logic [31:0] target_o
);

    assign pc_plus4_o = pcf_i + 32'd4;

    always_comb begin
        redirect_o = 1'b0;
        target_o   = pc_plus4_o;
        case (pcsrc_i)
            PCSRC_BRANCH: begin
                redirect_o = 1'b1;
                target_o   = pc_target_i;
            end
            PCSRC_JALR: begin
                redirect_o = 1'b1;
                target_o   = alu_result_i & ~32'h1;
            end
            default: ;  // reserved encoding behaves as sequential fetch
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, pending-redirect tracking and stall hold buffer.
// Optional MISALIGN_TRAP_EN adds sticky MisalignF and forces redirect targets word-aligned.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           PCSrc,
    input  logic [31:0]          PCTargetE,
    input  logic [31:0]          ALUResultE,
    input  logic                 Stall,
    input  logic                 FlushD,
    fetch_stage_if.master        imem,
    output logic [31:0]          InstrD,
    output logic [31:0]          PCD,
    output logic [31:0]          PCPlus4D,
    output logic                 ValidD
`ifdef MISALIGN_TRAP_EN
    ,
    output logic                 MisalignF
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pcf_q, pcf_d;
    logic         pend_v_q, pend_v_d;
    logic [31:0]  pend_pc_q, pend_pc_d;
    logic [31:0]  hold_instr_q, hold_instr_d;
    logic [31:0]  hold_pc_q, hold_pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pcd_q, pcd_d;
    logic [31:0]  pcp4_q, pcp4_d;
    logic         valid_q, valid_d;

    logic         redirect;
    logic [31:0]  target;
    logic [31:0]  redir_pc;
    logic [31:0]  pc_plus4;
    logic         req;
    logic         accept;

    pc_next_mux u_pc_next_mux (
        .pcf_i        (pcf_q),
        .pcsrc_i      (PCSrc),
        .pc_target_i  (PCTargetE),
        .alu_result_i (ALUResultE),
        .pc_plus4_o   (pc_plus4),
        .redirect_o   (redirect),
        .target_o     (target)
    );

`ifdef MISALIGN_TRAP_EN
    assign redir_pc = target & ~32'h3;
`else
    assign redir_pc = target;
`endif

    assign req       = (state_q == ST_WAIT) || ((state_q == ST_FETCH) && !Stall);
    assign accept    = req && imem.ready;
    assign imem.req  = req;
    assign imem.addr = pcf_q;

    always_comb begin
        state_d      = state_q;
        pcf_d        = pcf_q;
        pend_v_d     = pend_v_q;
        pend_pc_d    = pend_pc_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        instr_d      = instr_q;
        pcd_d        = pcd_q;
        pcp4_d       = pcp4_q;
        valid_d      = valid_q;

        if (state_q == ST_WAIT) begin
            if (accept) begin
                if (redirect || pend_v_q) begin
                    // the word in flight belongs to the wrong path
                    pcf_d    = redirect ? redir_pc : pend_pc_q;
                    pend_v_d = 1'b0;
                    valid_d  = 1'b0;
                    state_d  = ST_FETCH;
                end else if (!Stall) begin
                    instr_d = imem.rdata;
                    pcd_d   = pcf_q;
                    pcp4_d  = pc_plus4;
                    valid_d = 1'b1;
                    pcf_d   = pc_plus4;
                    state_d = ST_FETCH;
                end else begin
                    hold_instr_d = imem.rdata;
                    hold_pc_d    = pcf_q;
                    pcf_d        = pc_plus4;
                    state_d      = ST_HOLD;
                end
            end else begin
                valid_d = 1'b0;
                if (redirect) begin
                    pend_v_d  = 1'b1;
                    pend_pc_d = redir_pc;
                end
            end
        end else if (redirect) begin
            pcf_d   = redir_pc;
            valid_d = 1'b0;
            state_d = ST_FETCH;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    valid_d = 1'b0;
                    state_d = ST_FETCH;
                end
                ST_HOLD: begin
                    if (!Stall) begin
                        instr_d = hold_instr_q;
                        pcd_d   = hold_pc_q;
                        pcp4_d  = hold_pc_q + 32'd4;
                        valid_d = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
                default: begin
                    if (!Stall) begin
                        if (accept) begin
                            instr_d = imem.rdata;
                            pcd_d   = pcf_q;
                            pcp4_d  = pc_plus4;
                            valid_d = 1'b1;
                            pcf_d   = pc_plus4;
                        end else begin
                            valid_d = 1'b0;
                            state_d = ST_WAIT;
                        end
                    end
                end
            endcase
        end

        if (FlushD) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_BOOT;
            pcf_q        <= RESET_PC;
            pend_v_q     <= 1'b0;
            pend_pc_q    <= '0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            instr_q      <= '0;
            pcd_q        <= '0;
            pcp4_q       <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pcf_q        <= pcf_d;
            pend_v_q     <= pend_v_d;
            pend_pc_q    <= pend_pc_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            instr_q      <= instr_d;
            pcd_q        <= pcd_d;
            pcp4_q       <= pcp4_d;
            valid_q      <= valid_d;
        end
    end

    assign InstrD   = instr_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pcp4_q;
    assign ValidD   = valid_q;

`ifdef MISALIGN_TRAP_EN
    logic misalign_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else if (redirect && target[1]) begin
            misalign_q <= 1'b1;
        end
    end

    assign MisalignF = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a behavioural model predicts each cycle's outputs, a monitor compares.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  PCSrc;
    logic [31:0] PCTargetE;
    logic [31:0] ALUResultE;
    logic        Stall;
    logic        FlushD;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
`ifdef MISALIGN_TRAP_EN
    logic        MisalignF;
`endif

    always #5 clk = ~clk;

    fetch_stage_if imem_bus ();

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .PCSrc      (PCSrc),
        .PCTargetE  (PCTargetE),
        .ALUResultE (ALUResultE),
        .Stall      (Stall),
        .FlushD     (FlushD),
        .imem       (imem_bus),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD)
`ifdef MISALIGN_TRAP_EN
        ,
        .MisalignF  (MisalignF)
`endif
    );

    typedef struct {
        bit          chk;
        bit          req;
        logic [31:0] addr;
        bit          valid;
        bit          data_chk;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        bit          mis;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   started     = 1'b0;

    // Behavioural model: the program counter plus a few flags describing what the fetcher is doing.
    bit          m_known = 1'b0;
    bit          m_boot, m_wait, m_park, m_pend, m_fresh, m_mis;
    logic [31:0] m_pc, m_pend_pc, m_park_w, m_park_pc;
    bit          m_v;
    logic [31:0] m_i, m_p, m_p4;

    function automatic bit m_req(input bit stall);
        return !m_boot && !m_park && (m_wait || !stall);
    endfunction

    task automatic m_load(input logic [31:0] w, input logic [31:0] pc);
        m_i  = w;
        m_p  = pc;
        m_p4 = pc + 32'd4;
        m_v  = 1'b1;
    endtask

    task automatic model_step(input bit rst, input bit [1:0] src, input logic [31:0] pct,
                              input logic [31:0] alu, input bit stall, input bit flush,
                              input bit rdy, input logic [31:0] rdata);
        bit          acc, redir;
        logic [31:0] tgt;
        acc   = m_req(stall) && rdy;
        redir = (src == 2'd1) || (src == 2'd2);
        tgt   = (src == 2'd1) ? pct : (alu & ~32'd1);
        m_fresh = 1'b0;
        if (!rst) begin
            m_known = 1'b1; m_boot = 1'b1; m_wait = 1'b0; m_park = 1'b0; m_pend = 1'b0;
            m_pc = 32'h0; m_v = 1'b0; m_i = 32'h0; m_p = 32'h0; m_p4 = 32'h0;
            m_fresh = 1'b1; m_mis = 1'b0;
        end else begin
`ifdef MISALIGN_TRAP_EN
            if (redir && tgt[1]) m_mis = 1'b1;
            tgt = tgt & ~32'd3;
`endif
            if (m_wait) begin
                if (acc) begin
                    m_wait = 1'b0;
                    if (redir || m_pend) begin
                        m_pc   = redir ? tgt : m_pend_pc;
                        m_pend = 1'b0;
                        m_v    = 1'b0;
                    end else if (!stall) begin
                        m_load(rdata, m_pc);
                        m_pc = m_pc + 32'd4;
                    end else begin
                        m_park = 1'b1; m_park_w = rdata; m_park_pc = m_pc;
                        m_pc = m_pc + 32'd4;
                    end
                end else begin
                    m_v = 1'b0;
                    if (redir) begin
                        m_pend = 1'b1; m_pend_pc = tgt;
                    end
                end
            end else if (redir) begin
                m_pc = tgt; m_v = 1'b0; m_boot = 1'b0; m_park = 1'b0;
            end else if (m_boot) begin
                m_boot = 1'b0; m_v = 1'b0;
            end else if (m_park) begin
                if (!stall) begin
                    m_load(m_park_w, m_park_pc);
                    m_park = 1'b0;
                end
            end else if (!stall) begin
                if (acc) begin
                    m_load(rdata, m_pc);
                    m_pc = m_pc + 32'd4;
                end else begin
                    m_wait = 1'b1; m_v = 1'b0;
                end
            end
            if (flush) m_v = 1'b0;
        end
    endtask

    task automatic drive(input bit rst, input bit [1:0] src, input logic [31:0] pct,
                         input logic [31:0] alu, input bit stall, input bit flush, input bit rdy);
        exp_t e;
        @(posedge clk);
        #1;
        started        = 1'b1;
        rst_n          = rst;
        PCSrc          = src;
        PCTargetE      = pct;
        ALUResultE     = alu;
        Stall          = stall;
        FlushD         = flush;
        imem_bus.ready = rdy;
        imem_bus.rdata = $urandom;
        e.chk      = m_known;
        e.req      = m_req(stall);
        e.addr     = m_pc;
        e.valid    = m_v;
        e.data_chk = m_v || m_fresh;
        e.instr    = m_i;
        e.pc       = m_p;
        e.pc4      = m_p4;
        e.mis      = m_mis;
        exp_q.push_back(e);
        model_step(rst, src, pct, alu, stall, flush, rdy, imem_bus.rdata);
    endtask

    task automatic quiet(input int n);
        for (int k = 0; k < n; k++) drive(1'b1, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    vectors++;
                    cmp("imem_req", {31'b0, imem_bus.req}, {31'b0, e.req});
                    if (e.req) cmp("imem_addr", imem_bus.addr, e.addr);
                    cmp("ValidD", {31'b0, ValidD}, {31'b0, e.valid});
                    if (e.data_chk) begin
                        cmp("InstrD", InstrD, e.instr);
                        cmp("PCD", PCD, e.pc);
                        cmp("PCPlus4D", PCPlus4D, e.pc4);
                    end
`ifdef MISALIGN_TRAP_EN
                    cmp("MisalignF", {31'b0, MisalignF}, {31'b0, e.mis});
`endif
                end
            end else if (started) begin
                miscompares++;
                $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
            end
        end
    end

    initial begin
        bit [1:0]    src;
        logic [31:0] pct, alu;
        int          k;
        rst_n = 1'b0; PCSrc = 2'd0; PCTargetE = '0; ALUResultE = '0;
        Stall = 1'b0; FlushD = 1'b0; imem_bus.ready = 1'b0; imem_bus.rdata = '0;

        // reset, then free-running fetch
        drive(1'b0, 2'd0, 0, 0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 2'd0, 0, 0, 1'b0, 1'b0, 1'b1);
        quiet(6);
        // memory wait at 0x10
        drive(1'b1, 2'd1, 32'h10, 0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 3; n++) drive(1'b1, 2'd0, 0, 0, 1'b0, 1'b0, 1'b0);
        quiet(3);
        // redirect while waiting at 0x20
        drive(1'b1, 2'd1, 32'h20, 0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 2'd0, 0, 0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 2'd1, 32'h100, 0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 2'd0, 0, 0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 2'd0, 0, 0, 1'b0, 1'b0, 1'b1);
        quiet(3);
        // stalled accept at 0x40 goes through the hold buffer
        drive(1'b1, 2'd1, 32'h40, 0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 2'd0, 0, 0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 2'd0, 0, 0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 2'd0, 0, 0, 1'b1, 1'b0, 1'b1);
        quiet(3);
        // redirect overrides stall
        drive(1'b1, 2'd1, 32'h300, 0, 1'b1, 1'b0, 1'b1);
        quiet(2);
        // JALR to an odd, misaligned address, then reset
        drive(1'b1, 2'd2, 0, 32'h203, 1'b0, 1'b0, 1'b1);
        quiet(3);
        drive(1'b0, 2'd0, 0, 0, 1'b0, 1'b0, 1'b1);
        quiet(3);
        // PC wrap-around
        drive(1'b1, 2'd1, 32'hFFFF_FFF8, 0, 1'b0, 1'b0, 1'b1);
        quiet(4);
        // flush, alone and combined with stall
        drive(1'b1, 2'd0, 0, 0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 2'd0, 0, 0, 1'b1, 1'b1, 1'b1);
        quiet(3);
        // reserved PCSrc encoding
        drive(1'b1, 2'd3, 32'h500, 32'h600, 1'b0, 1'b0, 1'b1);
        quiet(2);

        for (int n = 0; n < 3000; n++) begin
            k = $urandom_range(0, 99);
            src = (k < 6) ? 2'd1 : (k < 10) ? 2'd2 : (k < 12) ? 2'd3 : 2'd0;
            pct = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15))
                                              : ($urandom & 32'h0000_0FFF);
            alu = $urandom & 32'h0000_0FFF;
            drive($urandom_range(0, 199) != 0, src, pct, alu,
                  $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 5,
                  $urandom_range(0, 99) < 65);
        end

        #10;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port: clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port: PCSrc  in  2  redirect select (00 PC+4, 01 branch/JAL target, 10 JALR target, 11 reserved).
REQ-005 SHALL have port: PCTargetE  in  32  PC+imm target.
REQ-006 SHALL have port: ALUResultE  in  32  JALR target.
REQ-007 SHALL have port: Stall  in  1  hold PC and IF/ID (hazard unit).
REQ-008 SHALL have port: FlushD  in  1  kill IF/ID contents.
REQ-009 SHALL have ports: imem_req  out  1;  imem_addr  out  32;  imem_ready  in  1  (accept and rdata valid in the same cycle);  imem_rdata  in  32.
REQ-010 SHALL have ports: InstrD  out  32;  PCD  out  32;  PCPlus4D  out  32;  ValidD  out  1.

Function
REQ-011 SHALL implement FSM states BOOT, FETCH, WAIT, HOLD; registered PCF, pending-redirect register (pend_v, pend_pc), hold buffer (hold_instr, hold_pc).
REQ-012 SHALL take redirect when PCSrc is 01 (target PCTargetE) or 10 (target ALUResultE with bit 0 cleared); 11 SHALL be treated as 00.
REQ-013 SHALL drive imem_addr = PCF and imem_req = 1 in WAIT, and in FETCH when Stall=0; imem_req = 0 in BOOT and HOLD.
REQ-014 SHALL hold imem_addr stable while imem_req=1 and imem_ready=0.
REQ-015 BOOT: SHALL go to FETCH after one cycle.
REQ-016 FETCH, accepted, no redirect: SHALL load IF/ID with {imem_rdata, PCF, PCF+4, Valid=1}; PCF <= PCF+4.
REQ-017 FETCH, not accepted: SHALL go to WAIT; IF/ID receives bubble (ValidD=0).
REQ-018 WAIT, accepted, no kill: if Stall=0, SHALL load IF/ID, advance PCF and go to FETCH; if Stall=1, SHALL capture data into hold buffer, advance PCF and go to HOLD.
REQ-019 HOLD: SHALL load IF/ID from hold buffer and go to FETCH on the first cycle with Stall=0.
REQ-020 Redirect in BOOT, FETCH or HOLD SHALL load PCF <= target, discard any accepted word and hold buffer, bubble IF/ID and go to FETCH, overriding Stall.
REQ-021 Redirect in WAIT with imem_ready=0 SHALL set pend_v=1, pend_pc=target; a later redirect SHALL overwrite pend_pc.
REQ-022 WAIT accept with pend_v=1 or a same-cycle redirect SHALL discard the data; PCF <= newest target; pend_v <= 0; go to FETCH.
REQ-023 FlushD=1 SHALL force ValidD <= 0 next cycle, overriding Stall; InstrD/PCD SHALL then be don't-care.
REQ-024 Stall=1 with no redirect and no FlushD SHALL hold IF/ID outputs unchanged.
REQ-025 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force state BOOT, PCF=RESET_PC, pend_v=0, ValidD=0, InstrD=PCD=PCPlus4D=0, imem_req=0, discarding any outstanding request.

Configuration
REQ-027 With MISALIGN_TRAP_EN defined: output MisalignF (1 bit) SHALL be a sticky flag set when an accepted redirect target has bit 1 set, cleared only by reset; PCF SHALL load target with bits [1:0] forced to 00.
REQ-028 Without MISALIGN_TRAP_EN: MisalignF SHALL be absent and target bit 1 SHALL pass through unchanged.

Structure
REQ-029 Shared package fetch_pkg SHALL hold the FSM state enum, PCSrc encoding constants and the default RESET_PC.
REQ-030 Next-PC selection SHALL be a combinational sub-module pc_next_mux; FSM, buffers and IF/ID registers SHALL remain in fetch_stage.

Verification
REQ-031 Reset release, imem_ready=1 always -> imem_addr sequence 0,4,8; ValidD rises in the third cycle after release with PCD=0.
REQ-032 imem_ready low 3 cycles at addr 0x10 -> addr held at 0x10, ValidD=0 for 3 cycles, then InstrD=rdata and PCD=0x10.
REQ-033 PCSrc=01, PCTargetE=0x100 during WAIT at 0x20, ready 2 cycles later -> 0x20 data discarded; next request addr 0x100.
REQ-034 Stall=1 in WAIT, accept at 0x40 -> HOLD; Stall released -> InstrD=that word, PCD=0x40, next addr 0x44.
REQ-035 PCSrc=10, ALUResultE=0x203, with MISALIGN_TRAP_EN defined -> MisalignF=1, next addr 0x200; rst_n=0 clears MisalignF.
REQ-036 PCSrc=01 and Stall=1 in the same FETCH cycle -> redirect taken, ValidD=0 next cycle.
